// File: rtl/xc_malu_issue.sv
// Issue/retire controller for the multi-cycle MALU: holds one instruction's operands
// until the MALU answers, returns the result as one or two writeback beats, then flushes.
module xc_malu_issue #(
    parameter bit          MASK_EN   = 1'b1,
    parameter logic [31:0] LFSR_SEED = 32'h6A09E667
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic [13:0] id_uop,
    input  logic [4:0]  id_pw,
    input  logic [31:0] id_rs1,
    input  logic [31:0] id_rs2,
    input  logic [31:0] id_rs3,
    input  logic [4:0]  id_rd,
    input  logic        id_sel_hi,
    input  logic        kill,

    output logic        malu_valid,
    output logic [13:0] malu_uop,
    output logic [4:0]  malu_pw,
    output logic [31:0] malu_rs1,
    output logic [31:0] malu_rs2,
    output logic [31:0] malu_rs3,
    output logic        malu_flush,
    output logic [31:0] malu_flush_data,
    input  logic [63:0] malu_result,
    input  logic        malu_ready,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        BUSY  = 5'b00010,
        WB_LO = 5'b00100,
        WB_HI = 5'b01000,
        FLUSH = 5'b10000
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    state_t      state_reg;
    state_t      state_next;
    logic [13:0] uop_reg;
    logic [4:0]  pw_reg;
    logic [31:0] rs1_reg;
    logic [31:0] rs2_reg;
    logic [31:0] rs3_reg;
    logic [4:0]  rd_reg;
    logic        sel_hi_reg;
    logic        pair_reg;
    logic [63:0] res_reg;
    logic [31:0] lfsr_reg;
    logic [31:0] lfsr_next;
    logic        accept;
    logic        capture;

    assign accept  = (state_reg == IDLE) && id_valid && !kill;
    assign capture = (state_reg == BUSY) && malu_ready && !kill;

    // Right-shifting Galois form; the feedback mask keeps the register out of the all-zero state.
    assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 32'h0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            lfsr_reg  <= LFSR_SEED;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            uop_reg    <= '0;
            pw_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rs3_reg    <= '0;
            rd_reg     <= '0;
            sel_hi_reg <= 1'b0;
            pair_reg   <= 1'b0;
        end else if (accept) begin
            uop_reg    <= id_uop;
            pw_reg     <= id_pw;
            rs1_reg    <= id_rs1;
            rs2_reg    <= id_rs2;
            rs3_reg    <= id_rs3;
            rd_reg     <= id_rd;
            sel_hi_reg <= id_sel_hi;
            pair_reg   <= |id_uop[13:10];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            res_reg <= '0;
        end else if (capture) begin
            res_reg <= malu_result;
        end
    end

    always_comb begin
        state_next      = state_reg;
        id_ready        = 1'b0;
        malu_valid      = 1'b0;
        malu_flush      = 1'b0;
        malu_flush_data = 32'h0;
        wb_valid        = 1'b0;
        wb_rd           = 5'h0;
        wb_data         = 32'h0;
        unique case (state_reg)
            IDLE: begin
                id_ready = !kill;
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                malu_valid = 1'b1;
                if (kill) begin
                    state_next = FLUSH;
                end else if (malu_ready) begin
                    state_next = WB_LO;
                end
            end
            WB_LO: begin
                wb_valid = 1'b1;
                if (pair_reg) begin
                    wb_rd   = {rd_reg[4:1], 1'b0};
                    wb_data = res_reg[31:0];
                end else begin
                    wb_rd   = rd_reg;
                    wb_data = sel_hi_reg ? res_reg[63:32] : res_reg[31:0];
                end
                // A beat accepted in the same cycle as kill still retires, but nothing follows it.
                if (kill) begin
                    state_next = FLUSH;
                end else if (wb_ready) begin
                    state_next = pair_reg ? WB_HI : FLUSH;
                end
            end
            WB_HI: begin
                wb_valid = 1'b1;
                wb_rd    = {rd_reg[4:1], 1'b1};
                wb_data  = res_reg[63:32];
                if (kill || wb_ready) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                malu_flush      = 1'b1;
                malu_flush_data = MASK_EN ? lfsr_reg : 32'h0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign malu_uop = uop_reg;
    assign malu_pw  = pw_reg;
    assign malu_rs1 = rs1_reg;
    assign malu_rs2 = rs2_reg;
    assign malu_rs3 = rs3_reg;

endmodule

// File: tb/tb_xc_malu_issue.sv
module tb_xc_malu_issue;

    localparam logic [31:0] SEED   = 32'h6A09E667;
    localparam logic [13:0] U_DIV  = 14'h0001;
    localparam logic [13:0] U_DIVU = 14'h0002;
    localparam logic [13:0] U_REMU = 14'h0008;
    localparam logic [13:0] U_MULU = 14'h0020;
    localparam logic [13:0] U_PMUL = 14'h0100;
    localparam logic [13:0] U_MMUL = 14'h2000;

    logic        clock;
    logic        resetn;
    logic        id_valid;
    logic        id_ready;
    logic [13:0] id_uop;
    logic [4:0]  id_pw;
    logic [31:0] id_rs1;
    logic [31:0] id_rs2;
    logic [31:0] id_rs3;
    logic [4:0]  id_rd;
    logic        id_sel_hi;
    logic        kill;
    logic        malu_valid;
    logic [13:0] malu_uop;
    logic [4:0]  malu_pw;
    logic [31:0] malu_rs1;
    logic [31:0] malu_rs2;
    logic [31:0] malu_rs3;
    logic        malu_flush;
    logic [31:0] malu_flush_data;
    logic [63:0] malu_result;
    logic        malu_ready;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;
    int edges;

    xc_malu_issue #(.MASK_EN(1'b1), .LFSR_SEED(SEED)) dut (
        .clock(clock), .resetn(resetn),
        .id_valid(id_valid), .id_ready(id_ready), .id_uop(id_uop), .id_pw(id_pw),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_rd(id_rd),
        .id_sel_hi(id_sel_hi), .kill(kill),
        .malu_valid(malu_valid), .malu_uop(malu_uop), .malu_pw(malu_pw),
        .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
        .malu_flush(malu_flush), .malu_flush_data(malu_flush_data),
        .malu_result(malu_result), .malu_ready(malu_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) edges <= 0;
        else         edges <= edges + 1;
    end

    function automatic logic [31:0] lfsr_adv(input int n);
        logic [31:0] v;
        v = SEED;
        for (int i = 0; i < n; i++)
            v = {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
        return v;
    endfunction

    task automatic chk(input string tag, input logic ok, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [13:0] uop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input logic hi);
        id_valid  = 1'b1;
        id_uop    = uop;
        id_pw     = 5'b00001;
        id_rs1    = a;
        id_rs2    = b;
        id_rs3    = c;
        id_rd     = rd;
        id_sel_hi = hi;
        chk("issue_id_ready", id_ready === 1'b1, id_ready, 1'b1);
        step();
        id_valid = 1'b0;
        id_uop   = '0;
        id_rs1   = '0;
        id_rs2   = '0;
        id_rs3   = '0;
        chk("busy_malu_valid", malu_valid === 1'b1, malu_valid, 1'b1);
        chk("busy_malu_uop", malu_uop === uop, malu_uop, uop);
        chk("busy_malu_rs1", malu_rs1 === a, malu_rs1, a);
        chk("busy_malu_rs2", malu_rs2 === b, malu_rs2, b);
        chk("busy_id_ready", id_ready === 1'b0, id_ready, 1'b0);
        $display("txn issue uop=%h rs1=%h rs2=%h rs3=%h rd=%0d sel_hi=%0d", uop, a, b, c, rd, hi);
    endtask

    task automatic respond(input logic [63:0] r);
        malu_ready  = 1'b1;
        malu_result = r;
        step();
        malu_ready  = 1'b0;
        malu_result = '0;
    endtask

    task automatic check_flush();
        logic [31:0] exp_data;
        exp_data = lfsr_adv(edges);
        chk("flush_strobe", malu_flush === 1'b1, malu_flush, 1'b1);
        chk("flush_wb_valid", wb_valid === 1'b0, wb_valid, 1'b0);
        chk("flush_malu_valid", malu_valid === 1'b0, malu_valid, 1'b0);
        chk("flush_data", malu_flush_data === exp_data, malu_flush_data, exp_data);
        $display("txn flush data=%h", malu_flush_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b1; id_valid = 1'b0; id_uop = '0; id_pw = '0; id_rs1 = '0; id_rs2 = '0;
        id_rs3 = '0; id_rd = '0; id_sel_hi = 1'b0; kill = 1'b0; malu_result = '0;
        malu_ready = 1'b0; wb_ready = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_id_ready", id_ready === 1'b1, id_ready, 1'b1);
        chk("rst_malu_valid", malu_valid === 1'b0, malu_valid, 1'b0);
        chk("rst_wb_valid", wb_valid === 1'b0, wb_valid, 1'b0);
        chk("rst_malu_flush", malu_flush === 1'b0, malu_flush, 1'b0);
        chk("rst_malu_uop", malu_uop === 14'h0, malu_uop, 14'h0);
        kill = 1'b1;
        #1;
        chk("rst_kill_id_ready", id_ready === 1'b0, id_ready, 1'b0);
        kill = 1'b0;
        #8 resetn = 1'b1;
        step();

        issue(U_DIVU, 32'd100, 32'd7, 32'd0, 5'd5, 1'b0);
        step();
        chk("divu_still_busy", malu_valid === 1'b1, malu_valid, 1'b1);
        respond({32'd2, 32'd14});
        chk("divu_wb_valid", wb_valid === 1'b1, wb_valid, 1'b1);
        chk("divu_wb_rd", wb_rd === 5'd5, wb_rd, 5'd5);
        chk("divu_wb_data", wb_data === 32'd14, wb_data, 32'd14);
        chk("divu_malu_valid", malu_valid === 1'b0, malu_valid, 1'b0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_flush();
        chk("divu_flush_nonzero", malu_flush_data != 32'h0, malu_flush_data, 1);
        step();
        chk("divu_after_flush", malu_flush === 1'b0, malu_flush, 1'b0);
        chk("divu_after_data", malu_flush_data === 32'h0, malu_flush_data, 32'h0);
        chk("divu_after_id_ready", id_ready === 1'b1, id_ready, 1'b1);
        chk("divu_single_beat", wb_valid === 1'b0, wb_valid, 1'b0);

        issue(U_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd3, 1'b1);
        respond(64'hFFFFFFFE_00000001);
        chk("mulu_wb_rd", wb_rd === 5'd3, wb_rd, 5'd3);
        chk("mulu_wb_data", wb_data === 32'hFFFFFFFE, wb_data, 32'hFFFFFFFE);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_flush();
        step();

        issue(U_MMUL, 32'h00010000, 32'h00010000, 32'd5, 5'd7, 1'b0);
        chk("mmul_malu_rs3", malu_rs3 === 32'd5, malu_rs3, 32'd5);
        respond(64'h00000001_00000005);
        chk("mmul_lo_rd", wb_rd === 5'd6, wb_rd, 5'd6);
        chk("mmul_lo_data", wb_data === 32'd5, wb_data, 32'd5);
        wb_ready = 1'b1;
        step();
        chk("mmul_hi_valid", wb_valid === 1'b1, wb_valid, 1'b1);
        chk("mmul_hi_rd", wb_rd === 5'd7, wb_rd, 5'd7);
        chk("mmul_hi_data", wb_data === 32'd1, wb_data, 32'd1);
        chk("mmul_hi_no_flush", malu_flush === 1'b0, malu_flush, 1'b0);
        step();
        wb_ready = 1'b0;
        check_flush();
        step();

        issue(U_REMU, 32'd100, 32'd7, 32'd0, 5'd9, 1'b0);
        respond({32'd0, 32'd2});
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_valid", wb_valid === 1'b1, wb_valid, 1'b1);
            chk("bp_wb_rd", wb_rd === 5'd9, wb_rd, 5'd9);
            chk("bp_wb_data", wb_data === 32'd2, wb_data, 32'd2);
            chk("bp_no_flush", malu_flush === 1'b0, malu_flush, 1'b0);
            step();
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_flush();
        step();

        issue(U_DIV, 32'd50, 32'd5, 32'd0, 5'd1, 1'b0);
        step();
        kill = 1'b1;
        chk("kill_no_wb", wb_valid === 1'b0, wb_valid, 1'b0);
        step();
        kill = 1'b0;
        check_flush();
        chk("kill_flush_nonzero", malu_flush_data != 32'h0, malu_flush_data, 1);
        step();
        issue(U_PMUL, 32'h11, 32'h22, 32'd0, 5'd2, 1'b0);
        respond(64'h0000ABCD_00001234);
        chk("after_kill_wb_data", wb_data === 32'h00001234, wb_data, 32'h00001234);
        chk("after_kill_wb_rd", wb_rd === 5'd2, wb_rd, 5'd2);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_flush();
        step();

        issue(U_MMUL, 32'd3, 32'd4, 32'd0, 5'd11, 1'b0);
        respond(64'h00000009_0000000C);
        chk("pairkill_lo_rd", wb_rd === 5'd10, wb_rd, 5'd10);
        kill = 1'b1;
        step();
        kill = 1'b0;
        check_flush();
        step();
        chk("pairkill_idle", id_ready === 1'b1, id_ready, 1'b1);

        issue(U_DIVU, 32'd9, 32'd3, 32'd0, 5'd4, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_malu_valid", malu_valid === 1'b0, malu_valid, 1'b0);
        chk("arst_wb_valid", wb_valid === 1'b0, wb_valid, 1'b0);
        chk("arst_malu_rs1", malu_rs1 === 32'h0, malu_rs1, 32'h0);
        chk("arst_id_ready", id_ready === 1'b1, id_ready, 1'b1);
        #2 resetn = 1'b1;
        step();
        issue(U_DIVU, 32'd9, 32'd3, 32'd0, 5'd4, 1'b0);
        respond({32'd0, 32'd3});
        chk("arst_wb_data", wb_data === 32'd3, wb_data, 32'd3);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_flush();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
